// File: rtl/csr_access_seq_pkg.sv
// Shared types and constants for the CSR access sequencer: FSM encoding,
// Zicsr funct3 codes, well-known CSR addresses and the read-only address predicate.
package csr_access_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } csr_state_e;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH = 12'hC80;

  // Addresses with [11:10]==2'b11 are the architecturally read-only space.
  function automatic logic is_ro_addr(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_wval_calc.sv
// Combinational CSR write-value calculator: new value and write enable from funct3/old/operand.
// No state, no latency; usable from any CSR path, sequenced or pipelined.
module csr_wval_calc
  import csr_access_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic            src_zero,
  output logic [XLEN-1:0] wdata,
  output logic            wr_en,
  output logic            f3_illegal
);

  always_comb begin
    wdata      = old_val;
    wr_en      = 1'b0;
    f3_illegal = 1'b0;
    // funct3[2] only selects the operand source, so decode on the low bits.
    unique case (funct3[1:0])
      2'b01: begin
        wdata = operand;
        wr_en = 1'b1;
      end
      2'b10: begin
        wdata = old_val | operand;
        wr_en = ~src_zero;
      end
      2'b11: begin
        wdata = old_val & ~operand;
        wr_en = ~src_zero;
      end
      default: f3_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_access_seq.sv
// Zicsr initiator: accept one request, read the CSR, optionally write it, return the old value.
// Optional macro CSR_RO_CHECK_EN flags writes to the read-only CSR space as illegal.
module csr_access_seq
  import csr_access_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [CSR_AW-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_rs1_data_i,
  input  logic [4:0]        req_rs1_idx_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_illegal_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              csr_we_o
);

  csr_state_e        state_q, state_d;
  logic [2:0]        funct3_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   operand_q;
  logic [4:0]        rs1_idx_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   wdata_q;
  logic              illegal_q;

  logic [XLEN-1:0]   calc_wdata;
  logic              calc_wr_en;
  logic              calc_f3_illegal;
  logic              illegal_c;
  logic              wr_en_c;

  csr_wval_calc #(.XLEN(XLEN)) u_wval_calc (
    .funct3     (funct3_q),
    .old_val    (csr_rdata_i),
    .operand    (operand_q),
    .src_zero   (rs1_idx_q == 5'd0),
    .wdata      (calc_wdata),
    .wr_en      (calc_wr_en),
    .f3_illegal (calc_f3_illegal)
  );

`ifdef CSR_RO_CHECK_EN
  assign illegal_c = calc_f3_illegal | (is_ro_addr(addr_q[11:0]) & calc_wr_en);
`else
  assign illegal_c = calc_f3_illegal;
`endif
  assign wr_en_c = calc_wr_en & ~illegal_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = READ;
      READ:    state_d = wr_en_c ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q  <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      rs1_idx_q <= '0;
      old_q     <= '0;
      wdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        funct3_q  <= req_funct3_i;
        addr_q    <= req_addr_i;
        operand_q <= req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;
        rs1_idx_q <= req_rs1_idx_i;
      end
      if (state_q == READ) begin
        old_q     <= csr_rdata_i;
        wdata_q   <= calc_wdata;
        illegal_q <= illegal_c;
      end
    end
  end

  // Strobe and handshakes decode straight from the async-reset state, so they drop with reset.
  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign csr_we_o      = (state_q == WRITE);
  assign rsp_illegal_o = (state_q == RESP) & illegal_q;
  assign rsp_rdata_o   = old_q;
  assign csr_addr_o    = addr_q;
  assign csr_wdata_o   = wdata_q;

endmodule

// File: tb/tb_csr_access_seq.sv
// Directed bench for csr_access_seq: latency, write data, suppression, illegality,
// response backpressure and reset abort, with hand-computed expectations.
module tb_csr_access_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_rs1_data_i;
  logic [4:0]  req_rs1_idx_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_illegal_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_rdata_i;
  logic [31:0] csr_wdata_o;
  logic        csr_we_o;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [31:0] we_wdata;
  logic [11:0] we_addr;
  int lat;

  always #5 clk_i = ~clk_i;

  csr_access_seq dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_rs1_data_i (req_rs1_data_i),
    .req_rs1_idx_i  (req_rs1_idx_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_illegal_o  (rsp_illegal_o),
    .csr_addr_o     (csr_addr_o),
    .csr_rdata_i    (csr_rdata_i),
    .csr_wdata_o    (csr_wdata_o),
    .csr_we_o       (csr_we_o)
  );

  // Write-strobe monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (csr_we_o) begin
      we_cnt   <= we_cnt + 1;
      we_wdata <= csr_wdata_o;
      we_addr  <= csr_addr_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] data, input logic [4:0] idx,
                           input logic [31:0] csr_val);
    we_cnt         = 0;
    csr_rdata_i    = csr_val;
    req_funct3_i   = f3;
    req_addr_i     = addr;
    req_rs1_data_i = data;
    req_rs1_idx_i  = idx;
    req_valid_i    = 1'b1;
    check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Counts posedges from the accept edge (inclusive) until rsp_valid_o is seen.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!rsp_valid_o) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid_o within %0d cycles", n);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_hs", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_funct3_i = '0; req_addr_i = '0;
    req_rs1_data_i = '0; req_rs1_idx_i = '0; rsp_ready_i = 1'b0; csr_rdata_i = '0;
    #12;
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_we", {31'd0, csr_we_o}, 32'd0);
    check("rst_illegal", {31'd0, rsp_illegal_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_addr", {20'd0, csr_addr_o}, 32'd0);
    check("rst_wdata", csr_wdata_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // CSRRW: write with rs1 value, old value returned at accept+3.
    start_req(3'b001, 12'h300, 32'hDEADBEEF, 5'd7, 32'h12345678);
    wait_rsp(lat);
    check("rw_latency", lat, 3);
    check("rw_rdata", rsp_rdata_o, 32'h12345678);
    check("rw_illegal", {31'd0, rsp_illegal_o}, 32'd0);
    check("rw_we_cnt", we_cnt, 1);
    check("rw_wdata", we_wdata, 32'hDEADBEEF);
    check("rw_waddr", {20'd0, we_addr}, 32'h300);
    finish_rsp();

    // CSRRS x0 on cycle: pure read, legal in both builds.
    start_req(3'b010, 12'hC00, 32'hFFFFFFFF, 5'd0, 32'h00000042);
    wait_rsp(lat);
    check("rs0_latency", lat, 2);
    check("rs0_rdata", rsp_rdata_o, 32'h42);
    check("rs0_illegal", {31'd0, rsp_illegal_o}, 32'd0);
    check("rs0_addr", {20'd0, csr_addr_o}, 32'hC00);
    finish_rsp();
    check("rs0_we_cnt", we_cnt, 0);

    // CSRRCI zimm=5: 0xFF & ~5 = 0xFA.
    start_req(3'b111, 12'h300, 32'h0, 5'b00101, 32'h000000FF);
    wait_rsp(lat);
    check("rci_latency", lat, 3);
    check("rci_we_cnt", we_cnt, 1);
    check("rci_wdata", we_wdata, 32'h000000FA);
    check("rci_rdata", rsp_rdata_o, 32'hFF);
    finish_rsp();

    // CSRRS rs1!=0: 0xF0 | 0x0F = 0xFF.
    start_req(3'b010, 12'h340, 32'h0000000F, 5'd3, 32'h000000F0);
    wait_rsp(lat);
    check("rs_we_cnt", we_cnt, 1);
    check("rs_wdata", we_wdata, 32'h000000FF);
    finish_rsp();

    // Reserved funct3 000: illegal, no write, old value still reported.
    start_req(3'b000, 12'h300, 32'h1, 5'd1, 32'hCAFEF00D);
    wait_rsp(lat);
    check("f3_latency", lat, 2);
    check("f3_illegal", {31'd0, rsp_illegal_o}, 32'd1);
    check("f3_rdata", rsp_rdata_o, 32'hCAFEF00D);
    finish_rsp();
    check("f3_we_cnt", we_cnt, 0);

    // CSRRW to cycleh: read-only space.
    start_req(3'b001, 12'hC80, 32'h55AA55AA, 5'd2, 32'h00000009);
    wait_rsp(lat);
`ifdef CSR_RO_CHECK_EN
    check("ro_illegal", {31'd0, rsp_illegal_o}, 32'd1);
    check("ro_latency", lat, 2);
`else
    check("ro_illegal", {31'd0, rsp_illegal_o}, 32'd0);
    check("ro_latency", lat, 3);
`endif
    check("ro_rdata", rsp_rdata_o, 32'h9);
    finish_rsp();
`ifdef CSR_RO_CHECK_EN
    check("ro_we_cnt", we_cnt, 0);
`else
    check("ro_we_cnt", we_cnt, 1);
`endif

    // Backpressure in RESP with a second request waiting.
    start_req(3'b101, 12'h305, 32'h0, 5'd17, 32'hA5A5A5A5);
    wait_rsp(lat);
    check("bp_wdata", we_wdata, 32'h00000011);
    req_funct3_i = 3'b010; req_addr_i = 12'h301; req_rs1_idx_i = 5'd0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("bp_rdata", rsp_rdata_o, 32'hA5A5A5A5);
      check("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    csr_rdata_i = 32'h0BADC0DE;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check("bp_idle_ready", {31'd0, req_ready_o}, 32'd1);
    check("bp_idle_valid", {31'd0, rsp_valid_o}, 32'd0);
    we_cnt = 0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("bp_second_accepted", {31'd0, req_ready_o}, 32'd0);
    wait_rsp(lat);
    check("bp2_latency", lat, 2);
    check("bp2_rdata", rsp_rdata_o, 32'h0BADC0DE);
    check("bp2_addr", {20'd0, csr_addr_o}, 32'h301);
    finish_rsp();
    check("bp2_we_cnt", we_cnt, 0);

    // Reset asserted while the write strobe is high.
    start_req(3'b001, 12'h300, 32'h11111111, 5'd1, 32'h22222222);
    @(posedge clk_i); #1;
    check("ra_in_write", {31'd0, csr_we_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("ra_we_drop", {31'd0, csr_we_o}, 32'd0);
    check("ra_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("ra_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("ra_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end
    rsp_ready_i = 1'b0;
    check("ra_ready_after", {31'd0, req_ready_o}, 32'd1);
    check("ra_we_cnt", we_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
